// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit positions, encoder and syndrome.
// Used by the encoder, the decoder and the read controller.
package hamming74_pkg;

  localparam int P1_BIT = 0;
  localparam int P2_BIT = 1;
  localparam int D0_BIT = 2;
  localparam int P3_BIT = 3;
  localparam int D1_BIT = 4;
  localparam int D2_BIT = 5;
  localparam int D3_BIT = 6;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] cw;
    cw         = '0;
    cw[D0_BIT] = d[0];
    cw[D1_BIT] = d[1];
    cw[D2_BIT] = d[2];
    cw[D3_BIT] = d[3];
    cw[P1_BIT] = d[0] ^ d[1] ^ d[3];
    cw[P2_BIT] = d[0] ^ d[2] ^ d[3];
    cw[P3_BIT] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

  // Returns {s3,s2,s1}; a nonzero value is the 1-based index of the flipped bit.
  function automatic logic [2:0] syndrome(input logic [6:0] cw);
    logic s1, s2, s3;
    s1 = cw[P1_BIT] ^ cw[D0_BIT] ^ cw[D1_BIT] ^ cw[D3_BIT];
    s2 = cw[P2_BIT] ^ cw[D0_BIT] ^ cw[D2_BIT] ^ cw[D3_BIT];
    s3 = cw[P3_BIT] ^ cw[D1_BIT] ^ cw[D2_BIT] ^ cw[D3_BIT];
    return {s3, s2, s1};
  endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational single-error corrector: flips the bit named by the syndrome
// and extracts the 4 data bits from the corrected codeword.
module hamming74_correct
  import hamming74_pkg::*;
(
  input  logic [6:0] cw_in,
  output logic [6:0] cw_out,
  output logic [3:0] data_out,
  output logic       err_out
);

  logic [2:0] syn;

  assign syn = syndrome(cw_in);

  for (genvar gi = 0; gi < 7; gi++) begin : g_fix
    assign cw_out[gi] = cw_in[gi] ^ (syn == 3'(gi + 1));
  end

  assign data_out = {cw_out[D3_BIT], cw_out[D2_BIT], cw_out[D1_BIT], cw_out[D0_BIT]};
  assign err_out  = |syn;

endmodule

// File: rtl/edc_mem_read_ctrl.sv
// Read controller for the Hamming(7,4) memory: fetch, correct, optional scrub
// write-back, then hold the response until the consumer takes it.
module edc_mem_read_ctrl
  import hamming74_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 8,
  parameter int SCRUB_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [6:0]        mem_wdata,
  input  logic [6:0]        mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [2:0] {IDLE, RD, CHK, WB, RSP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [6:0]          cw_q, cw_d;
  logic [3:0]          data_q, data_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [6:0]          fix_cw;
  logic [3:0]          fix_data;
  logic                fix_err;

  hamming74_correct u_correct (
    .cw_in   (mem_rdata),
    .cw_out  (fix_cw),
    .data_out(fix_data),
    .err_out (fix_err)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cw_d      = cw_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = RD;
        end
      end
      RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q;
        state_d   = CHK;
      end
      CHK: begin
        cw_d   = fix_cw;
        data_d = fix_data;
        err_d  = fix_err;
        if (fix_err && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = (fix_err && (SCRUB_EN != 0)) ? WB : RSP;
      end
      WB: begin
        mem_wr_en = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = cw_q;
        state_d   = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset also clears the response registers so rsp_* read zero until the first read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cw_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cw_q    <= cw_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign rsp_addr  = addr_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_edc_mem_read_ctrl.sv
// Scoreboard bench for edc_mem_read_ctrl: instance 0 scrubs, instance 1 does not.
// Stimulus pushes expected responses/writes; a negedge monitor pops and compares.
module tb_edc_mem_read_ctrl;

  localparam int AW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid [2];
  logic          req_ready [2];
  logic [AW-1:0] req_addr  [2];
  logic          mem_rd_en [2];
  logic          mem_wr_en [2];
  logic [AW-1:0] mem_addr  [2];
  logic [6:0]    mem_wdata [2];
  logic [6:0]    mem_rdata [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [3:0]    rsp_data  [2];
  logic          rsp_err   [2];
  logic [AW-1:0] rsp_addr  [2];
  logic [CW-1:0] err_count [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    edc_mem_read_ctrl #(
      .ADDR_W  (AW),
      .CNT_W   (CW),
      .SCRUB_EN((gi == 0) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[gi]),
      .req_ready(req_ready[gi]),
      .req_addr (req_addr[gi]),
      .mem_rd_en(mem_rd_en[gi]),
      .mem_wr_en(mem_wr_en[gi]),
      .mem_addr (mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]),
      .mem_rdata(mem_rdata[gi]),
      .rsp_valid(rsp_valid[gi]),
      .rsp_ready(rsp_ready[gi]),
      .rsp_data (rsp_data[gi]),
      .rsp_err  (rsp_err[gi]),
      .rsp_addr (rsp_addr[gi]),
      .err_count(err_count[gi])
    );
  end

  // Codeword memories with 1-cycle read latency, plus a preload port.
  logic [6:0]    mem [2][16];
  logic          pl_en = 1'b0;
  int            pl_inst = 0;
  logic [AW-1:0] pl_addr = '0;
  logic [6:0]    pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_inst][pl_addr] <= pl_data;
    for (int i = 0; i < 2; i++) begin
      if (mem_rd_en[i]) mem_rdata[i] <= mem[i][mem_addr[i]];
      if (mem_wr_en[i]) mem[i][mem_addr[i]] <= mem_wdata[i];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            inst;
    logic [AW-1:0] addr;
    logic [3:0]    data;
    logic          err;
    logic [CW-1:0] cnt;
    int            lat;
  } exp_t;

  typedef struct {
    int            inst;
    logic [AW-1:0] addr;
    logic [6:0]    wd;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares whatever the DUTs present against the queue heads.
  initial begin
    int   acc_cyc [2];
    bit   seen [2];
    exp_t e;
    wr_t  w;
    acc_cyc = '{0, 0};
    seen    = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            acc_cyc[i] = cyc;
            seen[i]    = 1'b0;
          end
          if (mem_wr_en[i]) begin
            chk("rd_wr_exclusive", 32'(mem_rd_en[i]), 32'd0);
            if (wr_q.size() == 0 || wr_q[0].inst != i) begin
              fail_now($sformatf("unexpected_write inst=%0d addr=%0h data=%0h", i, mem_addr[i], mem_wdata[i]));
            end else begin
              w = wr_q.pop_front();
              chk("scrub_addr", 32'(mem_addr[i]), 32'(w.addr));
              chk("scrub_wdata", 32'(mem_wdata[i]), 32'(w.wd));
            end
          end
          if (rsp_valid[i]) begin
            chk("req_ready_busy", 32'(req_ready[i]), 32'd0);
            chk("wdata_idle", 32'(mem_wdata[i]), 32'd0);
            if (exp_q.size() == 0 || exp_q[0].inst != i) begin
              fail_now($sformatf("unexpected_rsp inst=%0d addr=%0h", i, rsp_addr[i]));
            end else begin
              e = exp_q[0];
              chk("rsp_data", 32'(rsp_data[i]), 32'(e.data));
              chk("rsp_err", 32'(rsp_err[i]), 32'(e.err));
              chk("rsp_addr", 32'(rsp_addr[i]), 32'(e.addr));
              chk("err_count", 32'(err_count[i]), 32'(e.cnt));
              if (!seen[i]) begin
                seen[i] = 1'b1;
                chk("latency", 32'(cyc - acc_cyc[i]), 32'(e.lat));
              end
              if (rsp_ready[i]) begin
                void'(exp_q.pop_front());
                $display("txn inst=%0d addr=%0h data=%b err=%0b cnt=%0d",
                         i, rsp_addr[i], rsp_data[i], rsp_err[i], err_count[i]);
              end
            end
          end
        end
      end
    end
  end

  task automatic load(input int i, input logic [AW-1:0] a, input logic [6:0] d);
    pl_inst = i;
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic expect_rsp(input int i, input logic [AW-1:0] a, input logic [3:0] d,
                            input logic err, input int lat);
    exp_t e;
    if (err) exp_cnt[i] = (exp_cnt[i] < 255) ? exp_cnt[i] + 1 : 255;
    e.inst = i; e.addr = a; e.data = d; e.err = err; e.cnt = CW'(exp_cnt[i]); e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic expect_wr(input int i, input logic [AW-1:0] a, input logic [6:0] wd);
    wr_t w;
    w.inst = i; w.addr = a; w.wd = wd;
    wr_q.push_back(w);
  endtask

  task automatic request(input int i, input logic [AW-1:0] a);
    bit ok;
    ok           = 1'b0;
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready[i];
      @(posedge clk);
    end
    #1 req_valid[i] = 1'b0;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(posedge clk);
      ok = (exp_q.size() == 0) && (wr_q.size() == 0);
    end
    if (!ok) fail_now("completion_timeout");
    #1;
  endtask

  task automatic check_reset_outputs(input int i);
    chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en[i]), 32'd0);
    chk("rst_mem_wr_en", 32'(mem_wr_en[i]), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr[i]), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data[i]), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
    chk("rst_rsp_addr", 32'(rsp_addr[i]), 32'd0);
    chk("rst_err_count", 32'(err_count[i]), 32'd0);
  endtask

  initial begin
    bit ok;
    rst       = 1'b1;
    req_valid = '{1'b0, 1'b0};
    req_addr  = '{'0, '0};
    rsp_ready = '{1'b1, 1'b1};
    exp_cnt   = '{0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(posedge clk);
    #1;
    load(0, 4'd2, 7'b0000111);
    load(0, 4'd5, 7'b1110111);
    load(0, 4'd9, 7'b1100110);
    load(1, 4'd3, 7'b1000111);
    load(1, 4'd4, 7'b0000110);
    load(0, 4'd7, 7'b1110111);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean read
    expect_rsp(0, 4'd2, 4'b0001, 1'b0, 3);
    request(0, 4'd2);
    wait_done();

    // Single error with scrub, then re-read shows the repaired word
    expect_rsp(0, 4'd5, 4'b1111, 1'b1, 4);
    expect_wr(0, 4'd5, 7'b1111111);
    request(0, 4'd5);
    wait_done();
    expect_rsp(0, 4'd5, 4'b1111, 1'b0, 3);
    request(0, 4'd5);
    wait_done();

    // Error on the non-scrubbing instance: corrected, never written
    expect_rsp(1, 4'd3, 4'b0001, 1'b1, 3);
    request(1, 4'd3);
    wait_done();

    // Backpressure: response held, a second request is not accepted
    rsp_ready[0] = 1'b0;
    expect_rsp(0, 4'd9, 4'b1101, 1'b0, 3);
    request(0, 4'd9);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = rsp_valid[0];
    end
    if (!ok) fail_now("stall_rsp_timeout");
    req_valid[0] = 1'b1;
    req_addr[0]  = 4'hA;
    repeat (5) @(posedge clk);
    #1 req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    wait_done();
    repeat (6) @(posedge clk);
    #1;

    // Counter saturation on repeated single-bit errors
    for (int n = 0; n < 300; n++) begin
      expect_rsp(1, 4'd4, 4'b0001, 1'b1, 3);
      request(1, 4'd4);
      wait_done();
    end
    @(negedge clk);
    chk("err_count_saturated", 32'(err_count[1]), 32'd255);
    @(posedge clk);
    #1;

    // Reset while the scrub write is on the bus
    expect_rsp(0, 4'd7, 4'b1111, 1'b1, 4);
    expect_wr(0, 4'd7, 7'b1111111);
    request(0, 4'd7);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = mem_wr_en[0];
    end
    if (!ok) fail_now("wb_timeout");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    wr_q.delete();
    exp_cnt = '{0, 0};
    @(negedge clk);
    check_reset_outputs(0);
    chk("rst_err_count_1", 32'(err_count[1]), 32'd0);
    @(posedge clk);
    #1;
    expect_rsp(0, 4'd2, 4'b0001, 1'b0, 3);
    request(0, 4'd2);
    wait_done();

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
